conv_out_sequencer: RTL and testbench

//  Sits directly upstream of the result-capture/timing stage. Accepts one convolution engine's
//  2x2 output map as a valid/ready stream of wide accumulator words, row-major (00,01,10,11).

---
 rtl/conv_seq_pkg.sv | 27 ++
 rtl/acc_narrow.sv | 25 ++
 rtl/conv_out_sequencer.sv | 133 +++++++++++++
 tb/tb_conv_out_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/conv_seq_pkg.sv
// Shared encodings for the convolution output sequencer: FSM states and
// 2x2 output-map position indices.
package conv_seq_pkg;

  localparam int unsigned NUM_POS = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_GAP    = 3'd4,
    ST_DONE   = 3'd5
  } seq_state_t;

  localparam logic [IDX_W-1:0] POS_00 = 2'd0;
  localparam logic [IDX_W-1:0] POS_01 = 2'd1;
  localparam logic [IDX_W-1:0] POS_10 = 2'd2;
  localparam logic [IDX_W-1:0] POS_11 = 2'd3;

  // One-hot strobe vector for a map position; bit 0 is c00.
  function automatic logic [NUM_POS-1:0] pos_onehot(input logic [IDX_W-1:0] idx);
    pos_onehot = NUM_POS'(1) << idx;
  endfunction

endpackage

// File: rtl/acc_narrow.sv
// Combinational narrowing of an accumulator word: logical right shift, then
// truncate, or saturate when SEQ_SATURATE_EN is defined.
module acc_narrow #(
  parameter int unsigned ACC_W = 20,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned SHIFT = 0
) (
  input  logic [ACC_W-1:0] acc_data,
  output logic [OUT_W-1:0] res_c,
  output logic             ovf_hit_c
);

  logic [ACC_W-1:0] shifted;

  assign shifted   = acc_data >> SHIFT;
  // Any set bit above the result field means the value does not fit.
  assign ovf_hit_c = |shifted[ACC_W-1:OUT_W];

`ifdef SEQ_SATURATE_EN
  assign res_c = ovf_hit_c ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
`else
  assign res_c = shifted[OUT_W-1:0];
`endif

endmodule

// File: rtl/conv_out_sequencer.sv
// Streams a 2x2 accumulator map out as narrowed results with one-hot capture
// strobes. Saturating narrowing and the sticky ovf flag require SEQ_SATURATE_EN.
module conv_out_sequencer
  import conv_seq_pkg::*;
#(
  parameter int unsigned ACC_W = 20,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned SHIFT = 0,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             acc_valid,
  output logic             acc_ready,
  input  logic [ACC_W-1:0] acc_data,
  output logic [OUT_W-1:0] res_out,
  output logic             c00,
  output logic             c01,
  output logic             c10,
  output logic             c11,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic             ovf
);

`ifdef SEQ_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  seq_state_t         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   run_q, run_d, run_inc;
  logic [NUM_POS-1:0] strobe_d;
  logic               hs;
  logic [OUT_W-1:0]   narrow_res;
  logic               narrow_ovf;

  acc_narrow #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_narrow (
    .acc_data  (acc_data),
    .res_c     (narrow_res),
    .ovf_hit_c (narrow_ovf)
  );

  assign hs      = acc_valid & acc_ready;
  assign run_inc = (&run_q) ? run_q : run_q + CNT_W'(1);

  // Next-state, index and running-count logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    run_d   = run_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WAIT;
          idx_d   = POS_00;
          run_d   = '0;
        end
      end
      ST_WAIT: begin
        run_d = run_inc;
        if (hs) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        run_d   = run_inc;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        run_d   = run_inc;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        run_d = run_inc;
        if (idx_q == POS_11) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        run_d   = run_inc;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe for the position being presented; idx is stable through STROBE.
  assign strobe_d = (state_d == ST_STROBE) ? pos_onehot(idx_q) : '0;

  // Outputs are registered from next-state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      run_q     <= '0;
      res_out   <= '0;
      c00       <= 1'b0;
      c01       <= 1'b0;
      c10       <= 1'b0;
      c11       <= 1'b0;
      acc_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cyc_cnt   <= '0;
      ovf       <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      run_q     <= run_d;
      c00       <= strobe_d[0];
      c01       <= strobe_d[1];
      c10       <= strobe_d[2];
      c11       <= strobe_d[3];
      acc_ready <= (state_d == ST_WAIT);
      busy      <= (state_d != ST_IDLE);
      done      <= (state_d == ST_DONE);
      if (hs) res_out <= narrow_res;
      if (state_q == ST_DONE) cyc_cnt <= run_d;
      ovf       <= ovf | (hs & SAT_EN & narrow_ovf);
    end
  end

endmodule

// File: tb/tb_conv_out_sequencer.sv
// Directed bench for conv_out_sequencer: SHIFT=0 and SHIFT=4 instances share stimulus.
module tb_conv_out_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        acc_valid;
  logic [19:0] acc_data;

  logic        rdy0, rdy4;
  logic [7:0]  res0, res4;
  logic        c00, c01, c10, c11;
  logic        s00, s01, s10, s11;
  logic        busy0, busy4, done0, done4, ovf0, ovf4;
  logic [31:0] cyc0, cyc4;

  int checks = 0;
  int errors = 0;

  int         sc [4];
  logic [7:0] sr [4];
  logic [7:0] r4 [4];
  int         done_cyc;
  int         multi;

  always #5 clk = ~clk;

  conv_out_sequencer #(.ACC_W(20), .OUT_W(8), .SHIFT(0), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .start(start), .acc_valid(acc_valid), .acc_ready(rdy0),
    .acc_data(acc_data), .res_out(res0), .c00(c00), .c01(c01), .c10(c10), .c11(c11),
    .busy(busy0), .done(done0), .cyc_cnt(cyc0), .ovf(ovf0)
  );

  conv_out_sequencer #(.ACC_W(20), .OUT_W(8), .SHIFT(4), .CNT_W(32)) dut4 (
    .clk(clk), .rst(rst), .start(start), .acc_valid(acc_valid), .acc_ready(rdy4),
    .acc_data(acc_data), .res_out(res4), .c00(s00), .c01(s01), .c10(s10), .c11(s11),
    .busy(busy4), .done(done4), .cyc_cnt(cyc4), .ovf(ovf4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one frame; cycle 0 is the cycle start is high. Word 1 is withheld for
  // stall1 cycles of acc_ready; start is re-pulsed in cycle start_at (0 = never).
  task automatic run_frame(input logic [79:0] words, input int stall1, input int start_at);
    int  wi;
    int  wsel;
    int  stall_cnt;
    int  nstb;
    bit  hs;
    for (int i = 0; i < 4; i++) begin
      sc[i] = -1; sr[i] = '0; r4[i] = '0;
    end
    done_cyc = -1; wi = 0; stall_cnt = 0; multi = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      wsel      = (wi > 3) ? 3 : wi;
      acc_data  = words[wsel*20 +: 20];
      acc_valid = !(wi == 1 && stall_cnt < stall1);
      start     = (k == start_at);
      @(negedge clk);
      nstb = int'(c00) + int'(c01) + int'(c10) + int'(c11);
      if (nstb > 1) multi = 1;
      if (c00) begin sc[0] = k; sr[0] = res0; r4[0] = res4; end
      if (c01) begin sc[1] = k; sr[1] = res0; r4[1] = res4; end
      if (c10) begin sc[2] = k; sr[2] = res0; r4[2] = res4; end
      if (c11) begin sc[3] = k; sr[3] = res0; r4[3] = res4; end
      if (done0) done_cyc = k;
      hs = acc_valid && rdy0;
      if (wi == 1 && rdy0 && !acc_valid) stall_cnt++;
      @(posedge clk); #1;
      if (hs) wi++;
      if (done_cyc >= 0) break;
    end
    start = 1'b0;
    acc_valid = 1'b0;
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; acc_valid = 1'b0; acc_data = '0;

    // Reset held three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_strobes", {28'd0, c00, c01, c10, c11}, 32'd0);
    chk("rst_res", {24'd0, res0}, 32'd0);
    chk("rst_ready", {31'd0, rdy0}, 32'd0);
    chk("rst_busy_done", {30'd0, busy0, done0}, 32'd0);
    chk("rst_cyc", cyc0, 32'd0);
    chk("rst_ovf", {31'd0, ovf0}, 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_busy", {31'd0, busy0}, 32'd0);
    chk("idle_ready", {31'd0, rdy0}, 32'd0);

    // Basic frame 10,20,30,40
    @(posedge clk); #1;
    run_frame({20'd40, 20'd30, 20'd20, 20'd10}, 0, 0);
    chk("f1_c00_cyc", sc[0], 32'd3);
    chk("f1_c01_cyc", sc[1], 32'd7);
    chk("f1_c10_cyc", sc[2], 32'd11);
    chk("f1_c11_cyc", sc[3], 32'd15);
    chk("f1_res00", {24'd0, sr[0]}, 32'd10);
    chk("f1_res01", {24'd0, sr[1]}, 32'd20);
    chk("f1_res10", {24'd0, sr[2]}, 32'd30);
    chk("f1_res11", {24'd0, sr[3]}, 32'd40);
    chk("f1_done_cyc", done_cyc, 32'd17);
    chk("f1_cyc_cnt", cyc0, 32'd17);
    chk("f1_onehot", multi, 32'd0);
    chk("f1_ovf", {31'd0, ovf0}, 32'd0);
    chk("f1_idle_after", {31'd0, busy0}, 32'd0);

    // Overflow value 300
    run_frame({20'd3, 20'd2, 20'd1, 20'd300}, 0, 0);
`ifdef SEQ_SATURATE_EN
    chk("f2_res_sat", {24'd0, sr[0]}, 32'd255);
    chk("f2_ovf", {31'd0, ovf0}, 32'd1);
`else
    chk("f2_res_trunc", {24'd0, sr[0]}, 32'd44);
    chk("f2_ovf", {31'd0, ovf0}, 32'd0);
`endif
    chk("f2_res01", {24'd0, sr[1]}, 32'd1);

    // SHIFT=4 instance
    run_frame({20'd0, 20'd0, 20'h000F0, 20'h00A50}, 0, 0);
    chk("f3_shift4_res00", {24'd0, r4[0]}, 32'hA5);
    chk("f3_shift4_res01", {24'd0, r4[1]}, 32'h0F);
    chk("f3_shift4_ovf", {31'd0, ovf4}, 32'd0);

    // Stall before word 1 plus a start pulse mid-frame
    run_frame({20'd4, 20'd3, 20'd2, 20'd1}, 5, 8);
    chk("f4_c00_cyc", sc[0], 32'd3);
    chk("f4_c01_cyc", sc[1], 32'd12);
    chk("f4_c11_cyc", sc[3], 32'd20);
    chk("f4_res01", {24'd0, sr[1]}, 32'd2);
    chk("f4_done_cyc", done_cyc, 32'd22);
    chk("f4_cyc_cnt", cyc0, 32'd22);
    chk("f4_idle_after", {31'd0, busy0}, 32'd0);

    // Reset the cycle after the c01 strobe
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; acc_valid = 1'b1; acc_data = 20'd11;
    seen = 0;
    for (int k = 1; k <= 20 && seen == 0; k++) begin
      @(negedge clk);
      if (c01) seen = k;
      @(posedge clk); #1;
    end
    chk("f5_c01_seen", seen, 32'd7);
    rst = 1'b1; acc_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("f5_strobes", {28'd0, c00, c01, c10, c11}, 32'd0);
    chk("f5_busy", {31'd0, busy0}, 32'd0);
    chk("f5_res", {24'd0, res0}, 32'd0);
    chk("f5_ovf", {31'd0, ovf0}, 32'd0);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (done0) seen++;
      @(negedge clk);
    end
    chk("f5_no_done", seen, 32'd0);
    @(posedge clk); #1;
    run_frame({20'd88, 20'd77, 20'd66, 20'd55}, 0, 0);
    chk("f6_c00_cyc", sc[0], 32'd3);
    chk("f6_res00", {24'd0, sr[0]}, 32'd55);
    chk("f6_cyc_cnt", cyc0, 32'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
